// File: rtl/cache_block_fetcher_pkg.sv
// Shared definitions for the cache miss-fill path: width helpers and fetcher states.
package cache_block_fetcher_pkg;

  function automatic int unsigned blk_addr_width(input int unsigned addr_in_width,
                                                 input int unsigned block_width_bits);
    return addr_in_width - block_width_bits;
  endfunction

  function automatic int unsigned beats(input int unsigned block_width_bits);
    return 32'd1 << block_width_bits;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/cache_block_fetcher_line_assembler.sv
// Collects in-order memory responses into one cache line, one word per response.
module line_assembler
  import cache_block_fetcher_pkg::*;
#(
  parameter int unsigned DWIDTH           = 4,
  parameter int unsigned BLOCK_WIDTH_BITS = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    clear_i,
  input  logic                                    en_i,
  input  logic                                    rsp_valid_i,
  input  logic [DWIDTH-1:0]                       rsp_data_i,
  output logic [DWIDTH*beats(BLOCK_WIDTH_BITS)-1:0] line_o,
  output logic                                    last_o
);

  localparam int unsigned BEATS = beats(BLOCK_WIDTH_BITS);
  localparam int unsigned CNT_W = BLOCK_WIDTH_BITS + 1;
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

  logic [DWIDTH*BEATS-1:0] line_q, line_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr;

  assign wr     = en_i && rsp_valid_i && (cnt_q < BEATS_C);
  assign last_o = wr && (cnt_q == LAST_C);
  assign line_o = line_q;

  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wr) begin
      line_d[DWIDTH*cnt_q[BLOCK_WIDTH_BITS-1:0] +: DWIDTH] = rsp_data_i;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_block_fetcher.sv
// Miss-fill engine: issues BEATS word reads for a block and returns the assembled line.
module cache_block_fetcher
  import cache_block_fetcher_pkg::*;
#(
  parameter int unsigned DWIDTH           = 4,
  parameter int unsigned BLOCK_WIDTH_BITS = 4,
  parameter int unsigned ADDR_IN_WIDTH    = 16
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 req_valid,
  input  logic [blk_addr_width(ADDR_IN_WIDTH, BLOCK_WIDTH_BITS)-1:0] req_addr,
  output logic                                                 req_ready,
  output logic [DWIDTH*beats(BLOCK_WIDTH_BITS)-1:0]            blk_data,
  output logic                                                 mem_req_valid,
  output logic [ADDR_IN_WIDTH-1:0]                             mem_req_addr,
  input  logic                                                 mem_req_ready,
  input  logic                                                 mem_rsp_valid,
  input  logic [DWIDTH-1:0]                                    mem_rsp_data
);

  localparam int unsigned BAW   = blk_addr_width(ADDR_IN_WIDTH, BLOCK_WIDTH_BITS);
  localparam int unsigned BEATS = beats(BLOCK_WIDTH_BITS);
  localparam int unsigned CNT_W = BLOCK_WIDTH_BITS + 1;
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

  fetch_state_e             state_q, state_d;
  logic [CNT_W-1:0]         issue_cnt_q, issue_cnt_d;
  logic [BAW-1:0]           blk_addr_q, blk_addr_d;
  logic                     mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_IN_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic                     req_ready_q, req_ready_d;
  logic                     start;
  logic                     fill_last;

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;

  // Request outputs are computed one cycle ahead so they leave the block registered.
  always_comb begin
    state_d         = state_q;
    issue_cnt_d     = issue_cnt_q;
    blk_addr_d      = blk_addr_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    req_ready_d     = req_ready_q;
    start           = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b0;
        if (req_valid) begin
          start           = 1'b1;
          blk_addr_d      = req_addr;
          issue_cnt_d     = '0;
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = {req_addr, {BLOCK_WIDTH_BITS{1'b0}}};
          state_d         = FETCH;
        end
      end
      FETCH: begin
        if (mem_req_valid_q && mem_req_ready) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_d < BEATS_C) begin
            mem_req_addr_d = {blk_addr_q, issue_cnt_d[BLOCK_WIDTH_BITS-1:0]};
          end else begin
            mem_req_valid_d = 1'b0;
          end
        end
        if (fill_last) begin
          mem_req_valid_d = 1'b0;
          req_ready_d     = 1'b1;
          state_d         = DONE;
        end
      end
      DONE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      issue_cnt_q     <= '0;
      blk_addr_q      <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      req_ready_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      issue_cnt_q     <= issue_cnt_d;
      blk_addr_q      <= blk_addr_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      req_ready_q     <= req_ready_d;
    end
  end

  line_assembler #(
    .DWIDTH           (DWIDTH),
    .BLOCK_WIDTH_BITS (BLOCK_WIDTH_BITS)
  ) u_line_assembler (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (start),
    .en_i        (state_q == FETCH),
    .rsp_valid_i (mem_rsp_valid),
    .rsp_data_i  (mem_rsp_data),
    .line_o      (blk_data),
    .last_o      (fill_last)
  );

endmodule

// File: tb/tb_cache_block_fetcher.sv
// Directed bench for cache_block_fetcher with a latency-1 pipelined memory model.
module tb_cache_block_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [11:0] req_addr = '0;
  logic        req_ready;
  logic [63:0] blk_data;
  logic        mem_req_valid;
  logic [15:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_rsp_valid;
  logic [3:0]  mem_rsp_data;

  int total = 0;
  int bad   = 0;

  int          mem_mode = 0;
  bit          bp_en    = 1'b0;
  bit          stray_en = 1'b0;
  bit          mon_en   = 1'b0;
  logic [11:0] mon_blk  = '0;
  int          acc_cnt  = 0;
  bit          stall_q  = 1'b0;
  logic [15:0] stall_addr = '0;

  cache_block_fetcher #(
    .DWIDTH           (4),
    .BLOCK_WIDTH_BITS (4),
    .ADDR_IN_WIDTH    (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .blk_data      (blk_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] word_of(input int mode, input logic [3:0] beat);
    case (mode)
      1:       return 4'hB;
      2:       return ~beat;
      default: return beat;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pipelined memory: response one cycle after the accepting edge.
  always @(posedge clk) begin
    if (rst) begin
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= '0;
    end else if (stray_en) begin
      mem_rsp_valid <= 1'b1;
      mem_rsp_data  <= 4'h7;
    end else begin
      mem_rsp_valid <= mem_req_valid && mem_req_ready;
      mem_rsp_data  <= word_of(mem_mode, mem_req_addr[3:0]);
    end
  end

  always @(posedge clk) begin
    #2;
    if (bp_en) mem_req_ready = ~mem_req_ready;
  end

  // Issue monitor: every accepted address is the next beat; stalled requests hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_q) begin
        chk("hold_valid", 64'(mem_req_valid), 64'd1);
        chk("hold_addr", 64'(mem_req_addr), 64'(stall_addr));
      end
      if (mem_req_valid && mem_req_ready) begin
        chk("issue_addr", 64'(mem_req_addr), 64'({mon_blk, 4'(acc_cnt)}));
        acc_cnt++;
      end
      stall_q    = mem_req_valid && !mem_req_ready;
      stall_addr = mem_req_addr;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic run_fill(input logic [11:0] addr, input int mode, input bit bp,
                          input logic [63:0] line, input int rdy);
    int c;
    mem_mode  = mode;
    mon_blk   = addr;
    acc_cnt   = 0;
    mon_en    = 1'b1;
    req_addr  = addr;
    req_valid = 1'b1;
    @(posedge clk);
    bp_en = bp;
    for (c = 1; c <= 100; c++) begin
      cyc();
      if (c == 1) req_valid = 1'b0;
      if (!bp && c <= 16) begin
        chk("req_valid_c", 64'(mem_req_valid), 64'd1);
        chk("req_addr_c", 64'(mem_req_addr), 64'({addr, 4'(c - 1)}));
      end
      if (!bp && c == 17) chk("req_drop", 64'(mem_req_valid), 64'd0);
      if (req_ready) break;
    end
    bp_en         = 1'b0;
    mem_req_ready = 1'b1;
    chk("ready_seen", 64'(req_ready), 64'd1);
    if (rdy != 0) chk("ready_cycle", 64'(c), 64'(rdy));
    chk("issued_beats", 64'(acc_cnt), 64'd16);
    chk("line", blk_data, line);
    for (int i = 0; i < 16; i++)
      chk("hit_word", 64'(blk_data[4*i +: 4]), 64'(word_of(mode, 4'(i))));
  endtask

  task automatic handshake();
    req_valid = 1'b1;
    cyc();
    chk("hs_idle_ready", 64'(req_ready), 64'd0);
    chk("hs_idle_valid", 64'(mem_req_valid), 64'd0);
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic [11:0] addr;
    int          mode;
    bit          bp;
    logic [63:0] line;
    int          rdy;
    int          hold;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{addr: 12'hEAD, mode: 0, bp: 1'b0, line: 64'hFEDCBA9876543210, rdy: 18, hold: 5};
    vecs[1] = '{addr: 12'hEAD, mode: 0, bp: 1'b1, line: 64'hFEDCBA9876543210, rdy: 0,  hold: 0};
    vecs[2] = '{addr: 12'hEAE, mode: 1, bp: 1'b0, line: 64'hBBBBBBBBBBBBBBBB, rdy: 18, hold: 0};
    vecs[3] = '{addr: 12'hEBD, mode: 2, bp: 1'b0, line: 64'h0123456789ABCDEF, rdy: 18, hold: 0};

    repeat (3) cyc();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_mvalid", 64'(mem_req_valid), 64'd0);
    chk("rst_maddr", 64'(mem_req_addr), 64'd0);
    chk("rst_blk", blk_data, 64'd0);
    rst = 1'b0;
    cyc();

    for (int v = 0; v < 4; v++) begin
      run_fill(vecs[v].addr, vecs[v].mode, vecs[v].bp, vecs[v].line, vecs[v].rdy);
      for (int k = 0; k < vecs[v].hold; k++) begin
        cyc();
        chk("done_hold_ready", 64'(req_ready), 64'd1);
        chk("done_hold_line", blk_data, vecs[v].line);
      end
      handshake();
    end

    // Reset in the middle of a fetch, then stray responses while idle.
    cyc();
    mem_mode  = 0;
    mon_blk   = 12'hEAD;
    acc_cnt   = 0;
    mon_en    = 1'b1;
    req_addr  = 12'hEAD;
    req_valid = 1'b1;
    @(posedge clk);
    cyc();
    req_valid = 1'b0;
    for (int c = 0; c < 50 && acc_cnt < 7; c++) cyc();
    chk("mid_issued", 64'(acc_cnt), 64'd7);
    mon_en = 1'b0;
    rst    = 1'b1;
    cyc();
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_mvalid", 64'(mem_req_valid), 64'd0);
    chk("mid_rst_maddr", 64'(mem_req_addr), 64'd0);
    chk("mid_rst_blk", blk_data, 64'd0);
    rst      = 1'b0;
    stray_en = 1'b1;
    repeat (3) cyc();
    stray_en = 1'b0;
    repeat (2) cyc();
    chk("stray_blk", blk_data, 64'd0);
    chk("stray_ready", 64'(req_ready), 64'd0);
    chk("stray_mvalid", 64'(mem_req_valid), 64'd0);
    run_fill(12'hEAD, 0, 1'b0, 64'hFEDCBA9876543210, 18);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
